// File: rtl/taxi_axil_pkg.sv
// Shared AXI4-lite definitions: arbiter FSM states and response codes.
package taxi_axil_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-lite write-channel bundle with master and slave views.
interface taxi_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport wr_mst (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport wr_slv (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/taxi_arb_rr.sv
// Combinational round-robin / fixed-priority picker; shared by the read and write arbiters.
module taxi_arb_rr #(
    parameter int N    = 4,
    parameter int CL_N = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [CL_N-1:0] i_rr_ptr,
    input  logic            i_round_robin,
    output logic [N-1:0]    o_grant_oh,
    output logic [CL_N-1:0] o_grant_idx,
    output logic            o_grant_valid
);

    localparam logic [CL_N:0] N_W = (CL_N+1)'(N);

    logic [CL_N:0] w_base;
    logic [CL_N:0] w_cand;

    // Scan offsets from highest to lowest so the smallest offset from the base wins.
    always_comb begin
        w_base        = i_round_robin ? {1'b0, i_rr_ptr} : '0;
        w_cand        = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = w_base + (CL_N+1)'(k);
            if (w_cand >= N_W) begin
                w_cand = w_cand - N_W;
            end
            if (i_req[w_cand[CL_N-1:0]]) begin
                o_grant_idx   = w_cand[CL_N-1:0];
                o_grant_valid = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_oh
            assign o_grant_oh[gi] = o_grant_valid && (o_grant_idx == CL_N'(gi));
        end
    endgenerate

endmodule

// File: rtl/taxi_axil_wr_arb.sv
// AXI4-lite write arbiter: S_COUNT masters share one slave, one transaction in flight.
module taxi_axil_wr_arb
    import taxi_axil_pkg::*;
#(
    parameter int S_COUNT         = 4,
    parameter bit ARB_ROUND_ROBIN = 1'b1,
    localparam int CL_S_COUNT     = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic         clk,
    input  logic         rst,
    taxi_axil_if.wr_slv  s_axil_wr [S_COUNT],
    taxi_axil_if.wr_mst  m_axil_wr
);

    localparam int ADDR_W = m_axil_wr.ADDR_W;
    localparam int DATA_W = m_axil_wr.DATA_W;
    localparam int STRB_W = m_axil_wr.STRB_W;
    localparam logic [CL_S_COUNT-1:0] LAST_IDX = CL_S_COUNT'(S_COUNT - 1);

    arb_state_t              r_state, w_state_next;
    logic [CL_S_COUNT-1:0]   r_grant, w_grant_next;
    logic [S_COUNT-1:0]      r_grant_oh, w_grant_oh_next;
    logic [CL_S_COUNT-1:0]   r_rr_ptr, w_rr_ptr_next;
    logic                    r_aw_done, w_aw_done_next;
    logic                    r_w_done, w_w_done_next;

    logic [S_COUNT-1:0]      w_s_awvalid;
    logic [S_COUNT-1:0]      w_s_wvalid;
    logic [S_COUNT-1:0]      w_s_bready;
    logic [ADDR_W-1:0]       w_s_awaddr [S_COUNT];
    logic [2:0]              w_s_awprot [S_COUNT];
    logic [DATA_W-1:0]       w_s_wdata  [S_COUNT];
    logic [STRB_W-1:0]       w_s_wstrb  [S_COUNT];

    logic [S_COUNT-1:0]      w_arb_oh;
    logic [CL_S_COUNT-1:0]   w_arb_idx;
    logic                    w_arb_valid;

    logic w_in_xfer, w_in_resp;
    logic w_aw_hs, w_w_hs, w_b_hs;

    assign w_in_xfer = (r_state == XFER);
    assign w_in_resp = (r_state == RESP);

    generate
        for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
            assign w_s_awvalid[gi] = s_axil_wr[gi].awvalid;
            assign w_s_wvalid[gi]  = s_axil_wr[gi].wvalid;
            assign w_s_bready[gi]  = s_axil_wr[gi].bready;
            assign w_s_awaddr[gi]  = s_axil_wr[gi].awaddr;
            assign w_s_awprot[gi]  = s_axil_wr[gi].awprot;
            assign w_s_wdata[gi]   = s_axil_wr[gi].wdata;
            assign w_s_wstrb[gi]   = s_axil_wr[gi].wstrb;

            assign s_axil_wr[gi].awready = r_grant_oh[gi] && w_in_xfer && m_axil_wr.awready && !r_aw_done;
            assign s_axil_wr[gi].wready  = r_grant_oh[gi] && w_in_xfer && m_axil_wr.wready && !r_w_done;
            assign s_axil_wr[gi].bvalid  = r_grant_oh[gi] && w_in_resp && m_axil_wr.bvalid;
            assign s_axil_wr[gi].bresp   = (r_grant_oh[gi] && w_in_resp) ? m_axil_wr.bresp : OKAY;
        end
    endgenerate

    // Only awvalid counts as a request; a lone W beat waits for its address.
    taxi_arb_rr #(
        .N    (S_COUNT),
        .CL_N (CL_S_COUNT)
    ) u_arb (
        .i_req         (w_s_awvalid),
        .i_rr_ptr      (r_rr_ptr),
        .i_round_robin (ARB_ROUND_ROBIN),
        .o_grant_oh    (w_arb_oh),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

    assign m_axil_wr.awaddr  = w_s_awaddr[r_grant];
    assign m_axil_wr.awprot  = w_s_awprot[r_grant];
    assign m_axil_wr.wdata   = w_s_wdata[r_grant];
    assign m_axil_wr.wstrb   = w_s_wstrb[r_grant];
    assign m_axil_wr.awvalid = w_in_xfer && w_s_awvalid[r_grant] && !r_aw_done;
    assign m_axil_wr.wvalid  = w_in_xfer && w_s_wvalid[r_grant] && !r_w_done;
    assign m_axil_wr.bready  = w_in_resp && w_s_bready[r_grant];

    assign w_aw_hs = m_axil_wr.awvalid && m_axil_wr.awready;
    assign w_w_hs  = m_axil_wr.wvalid && m_axil_wr.wready;
    assign w_b_hs  = w_in_resp && m_axil_wr.bvalid && w_s_bready[r_grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_oh <= S_COUNT'(1);
            r_rr_ptr   <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_grant_oh <= w_grant_oh_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_aw_done  <= w_aw_done_next;
            r_w_done   <= w_w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_grant_oh_next = r_grant_oh;
        w_rr_ptr_next   = r_rr_ptr;
        w_aw_done_next  = r_aw_done;
        w_w_done_next   = r_w_done;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant_next    = w_arb_idx;
                    w_grant_oh_next = w_arb_oh;
                    w_aw_done_next  = 1'b0;
                    w_w_done_next   = 1'b0;
                    w_state_next    = XFER;
                end
            end
            XFER: begin
                if (w_aw_hs) w_aw_done_next = 1'b1;
                if (w_w_hs)  w_w_done_next  = 1'b1;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_state_next = IDLE;
                    // Explicit wrap keeps the pointer in range for non-power-of-two counts.
                    if (ARB_ROUND_ROBIN) begin
                        w_rr_ptr_next = (r_grant == LAST_IDX) ? '0 : r_grant + CL_S_COUNT'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_taxi_axil_wr_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter side by side, one line per write response.
module tb_taxi_axil_wr_arb;
    import taxi_axil_pkg::*;

    localparam int NP = 4;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        tb_awvalid [ND][NP];
    logic [31:0] tb_awaddr  [ND][NP];
    logic [2:0]  tb_awprot  [ND][NP];
    logic        tb_wvalid  [ND][NP];
    logic [31:0] tb_wdata   [ND][NP];
    logic [3:0]  tb_wstrb   [ND][NP];
    logic        tb_bready  [ND][NP];
    logic        ob_awready [ND][NP];
    logic        ob_wready  [ND][NP];
    logic        ob_bvalid  [ND][NP];
    logic [1:0]  ob_bresp   [ND][NP];

    logic        dn_awready [ND];
    logic        dn_wready  [ND];
    logic        dn_bvalid  [ND];
    logic [1:0]  dn_bresp   [ND];
    logic        om_awvalid [ND];
    logic [31:0] om_awaddr  [ND];
    logic [2:0]  om_awprot  [ND];
    logic        om_wvalid  [ND];
    logic [31:0] om_wdata   [ND];
    logic [3:0]  om_wstrb   [ND];
    logic        om_bready  [ND];

    // Instance 0 is round-robin, instance 1 is fixed priority.
    generate
        for (genvar dd = 0; dd < ND; dd++) begin : g_dut
            taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) s_if [NP] ();
            taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

            taxi_axil_wr_arb #(
                .S_COUNT         (NP),
                .ARB_ROUND_ROBIN ((dd == 0) ? 1'b1 : 1'b0)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .s_axil_wr (s_if),
                .m_axil_wr (m_if)
            );

            for (genvar gi = 0; gi < NP; gi++) begin : g_port
                assign s_if[gi].awaddr  = tb_awaddr[dd][gi];
                assign s_if[gi].awprot  = tb_awprot[dd][gi];
                assign s_if[gi].awvalid = tb_awvalid[dd][gi];
                assign s_if[gi].wdata   = tb_wdata[dd][gi];
                assign s_if[gi].wstrb   = tb_wstrb[dd][gi];
                assign s_if[gi].wvalid  = tb_wvalid[dd][gi];
                assign s_if[gi].bready  = tb_bready[dd][gi];
                assign ob_awready[dd][gi] = s_if[gi].awready;
                assign ob_wready[dd][gi]  = s_if[gi].wready;
                assign ob_bvalid[dd][gi]  = s_if[gi].bvalid;
                assign ob_bresp[dd][gi]   = s_if[gi].bresp;
            end

            assign m_if.awready   = dn_awready[dd];
            assign m_if.wready    = dn_wready[dd];
            assign m_if.bvalid    = dn_bvalid[dd];
            assign m_if.bresp     = dn_bresp[dd];
            assign om_awvalid[dd] = m_if.awvalid;
            assign om_awaddr[dd]  = m_if.awaddr;
            assign om_awprot[dd]  = m_if.awprot;
            assign om_wvalid[dd]  = m_if.wvalid;
            assign om_wdata[dd]   = m_if.wdata;
            assign om_wstrb[dd]   = m_if.wstrb;
            assign om_bready[dd]  = m_if.bready;
        end
    endgenerate

    int          n_checks = 0;
    int          n_pass   = 0;
    int          aw_cnt [ND];
    int          w_cnt  [ND];
    int          b_cnt  [ND][NP];
    bit          seen_rdy [ND][NP];
    logic [31:0] aw_log [ND][16];

    // Handshake monitor on the falling edge; counts what the next rising edge will complete.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                aw_cnt[d] = 0;
                w_cnt[d]  = 0;
                for (int p = 0; p < NP; p++) begin
                    b_cnt[d][p]    = 0;
                    seen_rdy[d][p] = 1'b0;
                end
            end else begin
                if (om_awvalid[d] && dn_awready[d]) begin
                    if (aw_cnt[d] < 16) aw_log[d][aw_cnt[d]] = om_awaddr[d];
                    aw_cnt[d]++;
                end
                if (om_wvalid[d] && dn_wready[d]) w_cnt[d]++;
                for (int p = 0; p < NP; p++) begin
                    if (ob_awready[d][p] || ob_wready[d][p] || ob_bvalid[d][p]) seen_rdy[d][p] = 1'b1;
                    if (ob_bvalid[d][p] && tb_bready[d][p]) begin
                        b_cnt[d][p]++;
                        $display("tx dut%0d port%0d bresp=%0d t=%0t", d, p, ob_bresp[d][p], $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < ND; d++) begin
            dn_awready[d] = 1'b0;
            dn_wready[d]  = 1'b0;
            dn_bvalid[d]  = 1'b0;
            dn_bresp[d]   = OKAY;
            for (int p = 0; p < NP; p++) begin
                tb_awvalid[d][p] = 1'b0;
                tb_awaddr[d][p]  = '0;
                tb_awprot[d][p]  = '0;
                tb_wvalid[d][p]  = 1'b0;
                tb_wdata[d][p]   = '0;
                tb_wstrb[d][p]   = '0;
                tb_bready[d][p]  = 1'b0;
            end
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < ND; d++) begin
            n_checks++; if (om_awvalid[d] !== 1'b0) $display("FAIL reset_m_awvalid dut%0d: got %b want 0", d, om_awvalid[d]); else n_pass++;
            n_checks++; if (om_wvalid[d] !== 1'b0) $display("FAIL reset_m_wvalid dut%0d: got %b want 0", d, om_wvalid[d]); else n_pass++;
            n_checks++; if (om_bready[d] !== 1'b0) $display("FAIL reset_m_bready dut%0d: got %b want 0", d, om_bready[d]); else n_pass++;
            for (int p = 0; p < NP; p++) begin
                n_checks++;
                if ({ob_awready[d][p], ob_wready[d][p], ob_bvalid[d][p]} !== 3'b000)
                    $display("FAIL reset_s_outputs dut%0d port%0d: got %b want 000", d, p, {ob_awready[d][p], ob_wready[d][p], ob_bvalid[d][p]});
                else n_pass++;
            end
        end
        rst = 1'b0;
        tick();
        n_checks++; if (om_awvalid[0] !== 1'b0) $display("FAIL reset_idle_no_req: got %b want 0", om_awvalid[0]); else n_pass++;
    endtask

    task automatic test_single();
        reset_all();
        dn_awready[0] = 1'b1;
        dn_wready[0]  = 1'b1;
        tb_awaddr[0][2]  = 32'h0000_0010;
        tb_awprot[0][2]  = 3'b010;
        tb_wdata[0][2]   = 32'hDEAD_BEEF;
        tb_wstrb[0][2]   = 4'hF;
        tb_bready[0][2]  = 1'b1;
        tb_awvalid[0][2] = 1'b1;
        tb_wvalid[0][2]  = 1'b1;
        #1;
        n_checks++; if (om_awvalid[0] !== 1'b0) $display("FAIL single_arb_cycle: m_awvalid=%b want 0", om_awvalid[0]); else n_pass++;
        tick();
        n_checks++; if (om_awvalid[0] !== 1'b1) $display("FAIL single_awvalid: got %b want 1", om_awvalid[0]); else n_pass++;
        n_checks++; if (om_awaddr[0] !== 32'h10) $display("FAIL single_awaddr: got %h want 00000010", om_awaddr[0]); else n_pass++;
        n_checks++; if (om_awprot[0] !== 3'b010) $display("FAIL single_awprot: got %b want 010", om_awprot[0]); else n_pass++;
        n_checks++; if (om_wvalid[0] !== 1'b1) $display("FAIL single_wvalid: got %b want 1", om_wvalid[0]); else n_pass++;
        n_checks++; if (om_wdata[0] !== 32'hDEAD_BEEF) $display("FAIL single_wdata: got %h want deadbeef", om_wdata[0]); else n_pass++;
        n_checks++; if (om_wstrb[0] !== 4'hF) $display("FAIL single_wstrb: got %h want f", om_wstrb[0]); else n_pass++;
        n_checks++; if ({ob_awready[0][2], ob_wready[0][2]} !== 2'b11) $display("FAIL single_s_ready: got %b want 11", {ob_awready[0][2], ob_wready[0][2]}); else n_pass++;
        tick();
        tb_awvalid[0][2] = 1'b0;
        tb_wvalid[0][2]  = 1'b0;
        n_checks++; if (aw_cnt[0] != 1 || w_cnt[0] != 1) $display("FAIL single_same_cycle: aw=%0d w=%0d want 1 1", aw_cnt[0], w_cnt[0]); else n_pass++;
        dn_bvalid[0] = 1'b1;
        dn_bresp[0]  = OKAY;
        #1;
        n_checks++; if (ob_bvalid[0][2] !== 1'b1) $display("FAIL single_bvalid: got %b want 1", ob_bvalid[0][2]); else n_pass++;
        n_checks++; if (ob_bresp[0][2] !== OKAY) $display("FAIL single_bresp: got %b want 00", ob_bresp[0][2]); else n_pass++;
        n_checks++; if (om_bready[0] !== 1'b1) $display("FAIL single_bready: got %b want 1", om_bready[0]); else n_pass++;
        tick();
        dn_bvalid[0] = 1'b0;
        n_checks++; if (b_cnt[0][2] != 1) $display("FAIL single_b_count: got %0d want 1", b_cnt[0][2]); else n_pass++;
        for (int p = 0; p < NP; p++) begin
            if (p != 2) begin
                n_checks++; if (seen_rdy[0][p] !== 1'b0) $display("FAIL single_isolation port%0d: got %b want 0", p, seen_rdy[0][p]); else n_pass++;
            end
        end
        tick();
        n_checks++; if (om_awvalid[0] !== 1'b0) $display("FAIL single_no_regrant: got %b want 0", om_awvalid[0]); else n_pass++;
    endtask

    task automatic test_split();
        reset_all();
        dn_wready[0] = 1'b1;
        tb_wdata[0][0]  = 32'hCAFE_F00D;
        tb_wstrb[0][0]  = 4'h3;
        tb_wvalid[0][0] = 1'b1;
        tb_bready[0][0] = 1'b1;
        tb_awaddr[0][0] = 32'h0000_0020;
        repeat (2) tick();
        n_checks++; if (om_wvalid[0] !== 1'b0) $display("FAIL split_w_alone_no_req: got %b want 0", om_wvalid[0]); else n_pass++;
        tick();
        tb_awvalid[0][0] = 1'b1;
        tick();
        n_checks++; if ({om_awvalid[0], om_wvalid[0]} !== 2'b11) $display("FAIL split_both_valid: got %b want 11", {om_awvalid[0], om_wvalid[0]}); else n_pass++;
        tick();
        // W completed; the master keeps wvalid up as if a further beat were queued.
        dn_bvalid[0] = 1'b1;
        dn_bresp[0]  = OKAY;
        #1;
        n_checks++; if (om_wvalid[0] !== 1'b0) $display("FAIL split_w_not_reissued: got %b want 0", om_wvalid[0]); else n_pass++;
        n_checks++; if (ob_wready[0][0] !== 1'b0) $display("FAIL split_wready_after_done: got %b want 0", ob_wready[0][0]); else n_pass++;
        n_checks++; if (om_awvalid[0] !== 1'b1) $display("FAIL split_aw_pending: got %b want 1", om_awvalid[0]); else n_pass++;
        n_checks++; if (ob_bvalid[0][0] !== 1'b0) $display("FAIL split_no_early_resp: got %b want 0", ob_bvalid[0][0]); else n_pass++;
        tick();
        n_checks++; if (ob_bvalid[0][0] !== 1'b0) $display("FAIL split_no_early_resp2: got %b want 0", ob_bvalid[0][0]); else n_pass++;
        n_checks++; if (aw_cnt[0] != 0 || w_cnt[0] != 1) $display("FAIL split_counts_mid: aw=%0d w=%0d want 0 1", aw_cnt[0], w_cnt[0]); else n_pass++;
        dn_awready[0] = 1'b1;
        tick();
        tb_awvalid[0][0] = 1'b0;
        tb_wvalid[0][0]  = 1'b0;
        #1;
        n_checks++; if (ob_bvalid[0][0] !== 1'b1) $display("FAIL split_resp_entered: got %b want 1", ob_bvalid[0][0]); else n_pass++;
        tick();
        dn_bvalid[0] = 1'b0;
        n_checks++; if (aw_cnt[0] != 1 || w_cnt[0] != 1 || b_cnt[0][0] != 1)
            $display("FAIL split_one_write: aw=%0d w=%0d b=%0d want 1 1 1", aw_cnt[0], w_cnt[0], b_cnt[0][0]);
        else n_pass++;
    endtask

    task automatic start_all(input int d, input int first);
        dn_awready[d] = 1'b1;
        dn_wready[d]  = 1'b1;
        dn_bvalid[d]  = 1'b1;
        dn_bresp[d]   = OKAY;
        for (int p = first; p < NP; p++) begin
            tb_awaddr[d][p]  = 32'h100 + 32'(p * 4);
            tb_wdata[d][p]   = 32'(p);
            tb_wstrb[d][p]   = 4'hF;
            tb_awvalid[d][p] = 1'b1;
            tb_wvalid[d][p]  = 1'b1;
            tb_bready[d][p]  = 1'b1;
        end
    endtask

    task automatic stop_all(input int d);
        for (int p = 0; p < NP; p++) begin
            tb_awvalid[d][p] = 1'b0;
            tb_wvalid[d][p]  = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [31:0] exp_addr;
        reset_all();
        start_all(0, 0);
        cyc = 0;
        while (aw_cnt[0] < 8 && cyc < 100) begin
            tick();
            cyc++;
        end
        stop_all(0);
        n_checks++; if (aw_cnt[0] < 8) $display("FAIL rr_timeout: got %0d writes want 8", aw_cnt[0]); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            exp_addr = 32'h100 + 32'((k % 4) * 4);
            n_checks++; if (aw_log[0][k] !== exp_addr) $display("FAIL rr_order[%0d]: got %h want %h", k, aw_log[0][k], exp_addr); else n_pass++;
        end
        repeat (4) tick();
        n_checks++; if (aw_cnt[0] != 8) $display("FAIL rr_drained: got %0d writes want 8", aw_cnt[0]); else n_pass++;
        dn_bvalid[0] = 1'b0;
    endtask

    task automatic test_fixed_priority();
        int cyc;
        reset_all();
        start_all(1, 0);
        cyc = 0;
        while (aw_cnt[1] < 8 && cyc < 100) begin
            tick();
            cyc++;
        end
        stop_all(1);
        n_checks++; if (aw_cnt[1] < 8) $display("FAIL fp_timeout: got %0d writes want 8", aw_cnt[1]); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (aw_log[1][k] !== 32'h100) $display("FAIL fp_order[%0d]: got %h want 00000100", k, aw_log[1][k]); else n_pass++;
        end
        repeat (2) tick();
        start_all(1, 1);
        cyc = 0;
        while (aw_cnt[1] < 9 && cyc < 20) begin
            tick();
            cyc++;
        end
        stop_all(1);
        n_checks++; if (aw_log[1][8] !== 32'h104 || aw_cnt[1] < 9) $display("FAIL fp_port1_wins: got %h (n=%0d) want 00000104", aw_log[1][8], aw_cnt[1]); else n_pass++;
        repeat (2) tick();
        dn_bvalid[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        reset_all();
        dn_awready[0] = 1'b1;
        dn_wready[0]  = 1'b1;
        tb_awaddr[0][1]  = 32'h14;
        tb_wdata[0][1]   = 32'h1234_5678;
        tb_wstrb[0][1]   = 4'hF;
        tb_awvalid[0][1] = 1'b1;
        tb_wvalid[0][1]  = 1'b1;
        repeat (2) tick();
        tb_awvalid[0][1] = 1'b0;
        tb_wvalid[0][1]  = 1'b0;
        dn_bvalid[0] = 1'b1;
        dn_bresp[0]  = SLVERR;
        tb_awaddr[0][3]  = 32'h30;
        tb_wstrb[0][3]   = 4'hF;
        tb_awvalid[0][3] = 1'b1;
        tb_wvalid[0][3]  = 1'b1;
        tb_bready[0][3]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (ob_bvalid[0][1] !== 1'b1) $display("FAIL bp_bvalid_held[%0d]: got %b want 1", i, ob_bvalid[0][1]); else n_pass++;
            n_checks++; if (ob_bresp[0][1] !== SLVERR) $display("FAIL bp_slverr[%0d]: got %b want 10", i, ob_bresp[0][1]); else n_pass++;
            n_checks++; if (om_awvalid[0] !== 1'b0 || ob_awready[0][3] !== 1'b0) $display("FAIL bp_no_grant[%0d]: got %b%b want 00", i, om_awvalid[0], ob_awready[0][3]); else n_pass++;
            tick();
        end
        tb_bready[0][1] = 1'b1;
        #1;
        n_checks++; if (om_bready[0] !== 1'b1) $display("FAIL bp_bready_pass: got %b want 1", om_bready[0]); else n_pass++;
        tick();
        dn_bvalid[0]    = 1'b0;
        tb_bready[0][1] = 1'b0;
        n_checks++; if (b_cnt[0][1] != 1) $display("FAIL bp_b_count: got %0d want 1", b_cnt[0][1]); else n_pass++;
        n_checks++; if (om_awvalid[0] !== 1'b0) $display("FAIL bp_idle_after_b: got %b want 0", om_awvalid[0]); else n_pass++;
        tick();
        n_checks++; if (om_awvalid[0] !== 1'b1 || om_awaddr[0] !== 32'h30) $display("FAIL bp_next_grant: got %b %h want 1 00000030", om_awvalid[0], om_awaddr[0]); else n_pass++;
        tick();
        tb_awvalid[0][3] = 1'b0;
        tb_wvalid[0][3]  = 1'b0;
        dn_bvalid[0] = 1'b1;
        dn_bresp[0]  = OKAY;
        tick();
        dn_bvalid[0] = 1'b0;
        n_checks++; if (b_cnt[0][3] != 1) $display("FAIL bp_port3_b: got %0d want 1", b_cnt[0][3]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        reset_all();
        dn_awready[0] = 1'b1;
        tb_awaddr[0][0]  = 32'h04;
        tb_wstrb[0][0]   = 4'hF;
        tb_awvalid[0][0] = 1'b1;
        tb_wvalid[0][0]  = 1'b1;
        tb_bready[0][0]  = 1'b1;
        repeat (2) tick();
        tb_awvalid[0][0] = 1'b0;
        dn_wready[0]     = 1'b1;
        tb_awaddr[0][3]  = 32'h30;
        tb_wstrb[0][3]   = 4'hF;
        tb_awvalid[0][3] = 1'b1;
        tb_wvalid[0][3]  = 1'b1;
        tb_bready[0][3]  = 1'b1;
        #1;
        n_checks++; if ({om_awvalid[0], om_wvalid[0], ob_wready[0][0]} !== 3'b011) $display("FAIL rstmid_pre: got %b want 011", {om_awvalid[0], om_wvalid[0], ob_wready[0][0]}); else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if ({om_awvalid[0], om_wvalid[0], om_bready[0]} !== 3'b000) $display("FAIL rstmid_m_async: got %b want 000", {om_awvalid[0], om_wvalid[0], om_bready[0]}); else n_pass++;
        for (int p = 0; p < NP; p++) begin
            n_checks++;
            if ({ob_awready[0][p], ob_wready[0][p], ob_bvalid[0][p]} !== 3'b000)
                $display("FAIL rstmid_s_async port%0d: got %b want 000", p, {ob_awready[0][p], ob_wready[0][p], ob_bvalid[0][p]});
            else n_pass++;
        end
        tb_wvalid[0][0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (om_awvalid[0] !== 1'b1 || om_awaddr[0] !== 32'h30 || ob_awready[0][3] !== 1'b1)
            $display("FAIL rstmid_port3_grant: got %b %h %b want 1 00000030 1", om_awvalid[0], om_awaddr[0], ob_awready[0][3]);
        else n_pass++;
        tick();
        tb_awvalid[0][3] = 1'b0;
        tb_wvalid[0][3]  = 1'b0;
        dn_bvalid[0] = 1'b1;
        tick();
        dn_bvalid[0] = 1'b0;
        n_checks++; if (b_cnt[0][3] != 1 || w_cnt[0] != 1) $display("FAIL rstmid_complete: b=%0d w=%0d want 1 1", b_cnt[0][3], w_cnt[0]); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_split();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_reset_mid();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/taxi_axil_wr_arb.md
Name: taxi_axil_wr_arb

Overview:
- Arbitrates S_COUNT AXI4-lite write masters onto one AXI4-lite write slave.
- Exactly one transaction is in flight at a time.
- Round-robin or fixed-priority selection, made in IDLE only.
- AW, W and B channels pass through combinationally to the granted port, gated by per-channel completion flags.
- Sits between multiple control-plane masters (CPU bridge, DMA config engine) and a shared register space.

Parameters:
- S_COUNT, 4: number of slave-side write ports, 1..16.
- ARB_ROUND_ROBIN, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.
- CL_S_COUNT, $clog2(S_COUNT) (min 1): derived grant index width; not user-set.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset: asynchronous, active-high.
- s_axil_wr  taxi_axil_if.wr_slv  array [S_COUNT]  Upstream write ports. ADDR_W, DATA_W and STRB_W come from the interface.
- m_axil_wr  taxi_axil_if.wr_mst  1  Downstream write port. Must share ADDR_W and DATA_W with s_axil_wr.

Behaviour:
- Reset state:
  - state = IDLE, grant = 0, rr_ptr = 0, aw_done = 0, w_done = 0.
  - All s awready, wready and bvalid are 0.
  - m awvalid, wvalid and bready are 0.
  - Reset mid-transaction abandons it; downstream must share rst.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - All outputs are deasserted.
  - Requesters are ports with awvalid = 1; wvalid alone does not request.
  - Round-robin: pick the first requester at index >= rr_ptr, wrapping modulo S_COUNT.
  - Fixed priority: pick the lowest requesting index.
  - If any requester exists, register grant = winner, clear aw_done and w_done, and go to XFER.
  - Arbitration cost is one cycle; the earliest m awvalid is the cycle after s awvalid is seen.
- XFER, with g = grant:
  - m awaddr/awprot = s[g] values. m awvalid = s[g].awvalid & !aw_done. s[g].awready = m awready & !aw_done.
  - m wdata/wstrb = s[g] values. m wvalid = s[g].wvalid & !w_done. s[g].wready = m wready & !w_done.
  - A handshake on AW sets aw_done; a handshake on W sets w_done.
  - Go to RESP when both are done, counting handshakes in the current cycle. Same-cycle AW+W gives XFER duration 1.
  - W may complete before AW and vice versa.
  - Non-granted ports see awready = wready = bvalid = 0.
- RESP:
  - s[g].bvalid = m bvalid; s[g].bresp = m bresp; m bready = s[g].bready.
  - On the B handshake go to IDLE.
  - If ARB_ROUND_ROBIN, set rr_ptr = (g+1) mod S_COUNT. Wrap is explicit when S_COUNT is not a power of two.
- A B handshake and a new request in the same cycle: the new grant is evaluated in the following IDLE cycle. Minimum back-to-back spacing is 3 cycles per transaction.
- Requests arriving during XFER or RESP wait. awvalid must stay asserted per AXI rules; the arbiter drops nothing.
- bresp passes unmodified. The block never generates SLVERR or DECERR itself.
- S_COUNT = 1 degenerates to a registered pass-through with the same FSM.

Decomposition:
- taxi_axil_pkg (shared) holds:
  - State enum typedef (IDLE/XFER/RESP).
  - AXI response constants: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
- Sub-module taxi_arb_rr (reusable):
  - Inputs: request vector, rr_ptr, mode.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational.
  - Shared later with the read-side twin, taxi_axil_rd_arb.

Test Plan:
- Single request: S_COUNT = 4; port 2 writes addr 0x10, data 0xDEADBEEF, strb 0xF with AW and W together; m awready = wready = 1.
  - m awvalid rises 1 cycle after s awvalid, and AW and W complete in that same cycle.
  - B OKAY returns to port 2 only; ports 0, 1 and 3 never see ready or bvalid.
- Split channels: port 0 presents W 3 cycles before AW; m awready is held low 2 extra cycles.
  - w_done sets first, and W is not re-issued.
  - RESP is entered only after AW completes, and exactly one downstream write is observed.
- Round-robin fairness: ports 0–3 all request continuously, 8 transactions.
  - Grant order is 0, 1, 2, 3, 0, 1, 2, 3.
- Fixed priority (ARB_ROUND_ROBIN = 0): the same stimulus.
  - Port 0 wins all 8.
  - With port 0 idle, port 1 wins.
- Backpressure and error: m bvalid with bresp = SLVERR while s[g].bready is held low 5 cycles.
  - bvalid stays asserted, and SLVERR is delivered unchanged.
  - No new grant is made until the B handshake.
- Reset mid-transaction: assert rst in XFER with aw_done = 1.
  - All readies and valids drop to 0 asynchronously; state returns to IDLE and rr_ptr to 0.
  - After release, port 3's request is granted normally.
